// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, status-word bit positions
// and the oversampling ratio.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int unsigned RX_VALID   = 8;
    localparam int unsigned RX_OVR     = 9;
    localparam int unsigned RX_FERR    = 10;
    localparam int unsigned OVERSAMPLE = 8;

endpackage

// File: rtl/uart_rx_if.sv
// CPU-side read bus of the UART receiver: request/ready handshake, read data
// and the FIFO-not-empty interrupt source.
interface uart_rx_if;

    logic        i_request;
    logic [31:0] o_rdata;
    logic        o_ready;
    logic        o_rx_avail;

    modport master (output i_request, input o_rdata, o_ready, o_rx_avail);
    modport slave  (input i_request, output o_rdata, o_ready, o_rx_avail);

endinterface

// File: rtl/uart_rx_fifo.sv
// Codebase first-word-fall-through FIFO with a synchronous flush on i_reset.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module fifo #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign o_empty = (count == '0);
    assign o_full  = (count == (AW+1)'(DEPTH));
    assign o_head  = mem[rd_ptr];
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    always_ff @(posedge i_clock) begin
        if (do_push && !i_reset) begin
            mem[wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 8x oversampling, a byte FIFO read over the
// request/ready bus, and sticky framing-error / overrun status bits.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000000 / (9600 * 8),
    parameter int unsigned DEPTH    = 64
) (
    input  logic      i_clock,
    input  logic      i_reset,
    uart_rx_if.slave  bus,
    input  logic      UART_RX
);

    localparam int unsigned    TW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [TW-1:0]  T_LAST  = TW'(PRESCALE - 1);
    localparam logic [2:0]     BT_LAST = 3'(OVERSAMPLE - 1);
    localparam logic [2:0]     BT_HALF = 3'(OVERSAMPLE / 2 - 1);

    rx_state_t     state, state_nx;
    logic          rx_meta, rx_s;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [2:0]    btick;
    logic [2:0]    bidx;
    logic [7:0]    shift;
    logic          bit_end;
    logic          start_det, start_ok, data_smp, stop_ok, stop_bad;
    logic          ferr, ovr, ovr_set;
    logic          ready;
    logic [31:0]   rdata, status_word;
    logic          read_now, pop;
    logic [7:0]    head;
    logic          empty, full;

    assign tick    = (tick_cnt == T_LAST);
    assign bit_end = tick && (btick == BT_LAST);

    always_comb begin
        state_nx  = state;
        start_det = 1'b0;
        start_ok  = 1'b0;
        data_smp  = 1'b0;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE: if (!rx_s) begin
                start_det = 1'b1;
                state_nx  = START;
            end
            START: if (tick && btick == BT_HALF) begin
                if (!rx_s) begin
                    start_ok = 1'b1;
                    state_nx = DATA;
                end else begin
                    state_nx = IDLE;
                end
            end
            DATA: if (bit_end) begin
                data_smp = 1'b1;
                if (bidx == 3'd7) state_nx = STOP;
            end
            // A good stop bit returns straight to IDLE so back-to-back frames are caught.
            STOP: if (bit_end) begin
                if (rx_s) begin
                    stop_ok  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    stop_bad = 1'b1;
                    state_nx = BREAK;
                end
            end
            BREAK: if (rx_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state    <= IDLE;
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            tick_cnt <= '0;
            btick    <= '0;
            bidx     <= '0;
            shift    <= '0;
        end else begin
            state    <= state_nx;
            rx_meta  <= UART_RX;
            rx_s     <= rx_meta;
            tick_cnt <= (start_det || tick) ? '0 : tick_cnt + 1'b1;
            if (start_det || start_ok) begin
                btick <= '0;
            end else if (tick) begin
                btick <= btick + 1'b1;
            end
            if (start_ok) begin
                bidx <= '0;
            end else if (data_smp) begin
                shift[bidx] <= rx_s;
                bidx        <= bidx + 1'b1;
            end
        end
    end

    assign read_now = bus.i_request && !ready;
    assign pop      = read_now && !empty;
    assign ovr_set  = stop_ok && full && !pop;

    always_comb begin
        status_word          = '0;
        status_word[RX_FERR] = ferr;
        status_word[RX_OVR]  = ovr;
        status_word[RX_VALID] = !empty;
        status_word[7:0]     = empty ? '0 : head;
    end

    // Sets are written after the read-clear so a same-cycle set wins.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            ferr  <= 1'b0;
            ovr   <= 1'b0;
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            if (read_now) begin
                ferr  <= 1'b0;
                ovr   <= 1'b0;
                ready <= 1'b1;
                rdata <= status_word;
            end else if (!bus.i_request) begin
                ready <= 1'b0;
            end
            if (stop_bad) ferr <= 1'b1;
            if (ovr_set)  ovr  <= 1'b1;
        end
    end

    assign bus.o_ready    = ready;
    assign bus.o_rdata    = rdata;
    assign bus.o_rx_avail = !empty;

    fifo #(
        .DEPTH(DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (stop_ok),
        .i_wdata (shift),
        .i_pop   (pop),
        .o_head  (head),
        .o_empty (empty),
        .o_full  (full)
    );

endmodule
